// File: rtl/sevenseg_scan_n.sv
// sevenseg_scan_n: multiplexed common-anode 7-segment driver with tear-free shadow update
module sevenseg_scan_n #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [7:0]              SevenSegment,
  output logic [NUM_DIGITS-1:0]   SevenSegmentEnable,
  output logic                    frame_done
);
  localparam int W  = 4*NUM_DIGITS;
  localparam int SW = W + 2*NUM_DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         pending, shadow, inputs;
  logic [W-1:0]          sh_val;
  logic [NUM_DIGITS-1:0] sh_dp, sh_blank, lz;
  logic                  tick, wrap, dark;
  logic [3:0]            nib;
  logic [7:0]            seg_next;
  assign inputs   = {value, dp_in, blank_in};
  assign sh_val   = shadow[SW-1 -: W];
  assign sh_dp    = shadow[2*NUM_DIGITS-1 -: NUM_DIGITS];
  assign sh_blank = shadow[NUM_DIGITS-1:0];
  assign tick     = cnt == CW'(SCAN_DIV-1);
  assign wrap     = tick && idx == IW'(NUM_DIGITS-1);
  // a digit is a leading zero when it and every more significant nibble is zero
  always_comb begin
    logic nz;
    nz = 1'b0;
    lz = '0;
    for (int k = NUM_DIGITS-1; k >= 1; k--) begin
      nz = nz | (sh_val[4*k +: 4] != 4'h0);
      lz[k] = lz_blank & ~nz;
    end
  end
  assign nib      = sh_val[{idx, 2'b00} +: 4];
  assign dark     = sh_blank[idx] | lz[idx];
  assign seg_next = {dark ? 7'h7F : LUT[nib], ~sh_dp[idx]};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                <= '0;
      idx                <= '0;
      pending            <= '0;
      shadow             <= '0;
      SevenSegment       <= 8'hFF;
      SevenSegmentEnable <= '1;
      frame_done         <= 1'b0;
    end else begin
      cnt                <= tick ? '0 : cnt + 1'b1;
      if (tick) idx      <= idx == IW'(NUM_DIGITS-1) ? '0 : idx + 1'b1;
      if (load) pending  <= inputs;
      if (wrap) shadow   <= load ? inputs : pending;
      SevenSegment       <= seg_next;
      SevenSegmentEnable <= cnt < CW'(BLANK_CYC) ? '1 : ~(NUM_DIGITS'(1) << idx);
      frame_done         <= wrap;
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_n.sv
// tb_sevenseg_scan_n: arithmetic scan model checked every cycle, plus literal slot checks
module tb_sevenseg_scan_n;
  localparam int N = 3, D = 4, B = 1;
  logic clk = 0, rst = 1, lz_blank = 0, load = 0;
  logic [11:0] value = 0;
  logic [2:0] dp_in = 0, blank_in = 0;
  logic [7:0] SevenSegment;
  logic [2:0] SevenSegmentEnable;
  logic frame_done;
  int vectors = 0, miscompares = 0, t = 0;
  bit mvalid = 0;
  logic [11:0] pend_v, shad_v;
  logic [2:0] pend_dp, shad_dp, pend_bl, shad_bl;
  logic [7:0] exp_seg;
  logic [2:0] exp_en;
  logic exp_fd;
  logic [6:0] dec [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000,
    7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  sevenseg_scan_n #(.NUM_DIGITS(N), .SCAN_DIV(D), .BLANK_CYC(B)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_in(blank_in),
    .lz_blank(lz_blank), .load(load), .SevenSegment(SevenSegment),
    .SevenSegmentEnable(SevenSegmentEnable), .frame_done(frame_done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s t=%0d got=%b want=%b", name, t, act, want);
    end
  endtask

  // model: outputs after edge t describe slot position s=t-1 of a free-running scan
  always @(posedge clk) begin
    int s, i;
    logic [11:0] sh;
    if (rst) begin
      t = 0; mvalid = 1;
      pend_v = 0; pend_dp = 0; pend_bl = 0; shad_v = 0; shad_dp = 0; shad_bl = 0;
      exp_seg = 8'hFF; exp_en = 3'b111; exp_fd = 0;
    end else begin
      s = t;
      i = (s / D) % N;
      sh = shad_v >> (4*i);
      exp_en = (s % D) < B ? 3'b111 : ~(3'b001 << i);
      exp_seg = {(shad_bl[i] || (lz_blank && i >= 1 && sh == 0)) ? 7'h7F : dec[sh[3:0]], ~shad_dp[i]};
      exp_fd = (s + 1) % (D*N) == 0;
      if (load) begin pend_v = value; pend_dp = dp_in; pend_bl = blank_in; end
      if ((s + 1) % (D*N) == 0) begin shad_v = pend_v; shad_dp = pend_dp; shad_bl = pend_bl; end
      t = t + 1;
    end
  end

  always @(negedge clk) if (!rst && mvalid) begin
    chk("seg", SevenSegment, exp_seg);
    chk("en", {5'b0, SevenSegmentEnable}, {5'b0, exp_en});
    chk("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
  end

  task automatic lit(input int target, input logic [7:0] s, input logic [2:0] e, input logic f);
    while (t < target) @(negedge clk);
    chk("lit_seg", SevenSegment, s);
    chk("lit_en", {5'b0, SevenSegmentEnable}, {5'b0, e});
    chk("lit_fd", {7'b0, frame_done}, {7'b0, f});
  endtask

  task automatic ld(input int target, input logic [11:0] v, input logic [2:0] dp,
                    input logic [2:0] bl, input logic lz);
    while (t < target - 1) @(negedge clk);
    value = v; dp_in = dp; blank_in = bl; lz_blank = lz; load = 1;
    @(negedge clk);
    load = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 0;
    ld(2, 12'h3A7, 3'b010, 3'b000, 0);
    lit(13, 8'b00011111, 3'b111, 0);
    lit(14, 8'b00011111, 3'b110, 0);
    lit(17, 8'b00010000, 3'b111, 0);
    lit(18, 8'b00010000, 3'b101, 0);
    lit(21, 8'b00001101, 3'b111, 0);
    lit(22, 8'b00001101, 3'b011, 0);
    lit(24, 8'b00001101, 3'b011, 1);
    lit(25, 8'b00011111, 3'b111, 0);
    ld(30, 12'h123, 3'b010, 3'b000, 0);
    lit(33, 8'b00001101, 3'b111, 0);
    lit(36, 8'b00001101, 3'b011, 1);
    lit(37, 8'b00001101, 3'b111, 0);
    lit(41, 8'b00100100, 3'b111, 0);
    ld(44, 12'h005, 3'b000, 3'b000, 1);
    lit(49, 8'b01001001, 3'b111, 0);
    lit(54, 8'hFF, 3'b101, 0);
    lit(58, 8'hFF, 3'b011, 0);
    ld(59, 12'h000, 3'b000, 3'b000, 1);
    lit(61, 8'b00000011, 3'b111, 0);
    lit(65, 8'hFF, 3'b111, 0);
    lit(70, 8'hFF, 3'b011, 0);
    ld(74, 12'h111, 3'b000, 3'b000, 0);
    ld(84, 12'h888, 3'b000, 3'b000, 0);
    lit(85, 8'b00000001, 3'b111, 0);
    lit(90, 8'b00000001, 3'b101, 0);
    lit(96, 8'b00000001, 3'b011, 1);
    ld(98, 12'h456, 3'b000, 3'b001, 0);
    lit(109, 8'hFF, 3'b111, 0);
    lit(110, 8'hFF, 3'b110, 0);
    lit(113, 8'b01001001, 3'b111, 0);
    lit(117, 8'b10011001, 3'b111, 0);
    lit(118, 8'b10011001, 3'b011, 0);
    lit(120, 8'b10011001, 3'b011, 1);
    #1 rst = 1;
    #1;
    chk("rst_seg", SevenSegment, 8'hFF);
    chk("rst_en", {5'b0, SevenSegmentEnable}, 8'h07);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    @(negedge clk);
    rst = 0;
    lit(1, 8'b00000011, 3'b111, 0);
    lit(2, 8'b00000011, 3'b110, 0);
    lit(5, 8'b00000011, 3'b111, 0);
    lit(12, 8'b00000011, 3'b011, 1);
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
